demux1_2_flops: RTL
===================

// Module: demux1_2_flops
// PURPOSE
//  1:2 demultiplexer; the distribution counterpart of the registered 2:1 mux.
//  - Accepts one BW-bit word per cycle over a valid/ready handshake.
//  - Routes each word to output 0 or 1 and buffers it there in a DEPTH-entry FIFO.
//  - Sits between a single producer and two independent downstream consumers.
// PARAMETERS
//  BW     2  data width in bits
//  DEPTH  4  entries per output FIFO; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
//  clk        in   1   single clock; all state on posedge clk
//  reset_L    in   1   asynchronous active-low reset; sync deassert is upstream's job
//  selector   in   1   destination of the current word: 0 -> out0, 1 -> out1
//  valid_in   in   1   data_in holds a word
//  data_in    in   BW  input word
//  ready_in   out  1   block accepts the word this cycle
//  pop0       in   1   consumer 0 takes the head of FIFO 0
//  valid_out0 out  1   FIFO 0 not empty
//  data_out0  out  BW  head of FIFO 0 (first-word fall-through)
//  pop1       in   1   consumer 1 takes the head of FIFO 1
//  valid_out1 out  1   FIFO 1 not empty
//  data_out1  out  BW  head of FIFO 1 (first-word fall-through)
// BEHAVIOUR
//  - Reset (reset_L=0, any time, immediately):
//    - FIFO counts, read/write pointers and the rr pointer go to 0.
//    - Storage clears to 0, so valid_out0/1 = 0 and data_out0/1 = 0.
//    - Words in flight are discarded.
//  - Target selection: tgt = selector (or rr_ptr, see CONFIGURATION).
//  - ready_in = !full[tgt]. This is combinational from tgt and the counts only.
//    - It never depends on pop0/pop1, so there is no same-cycle pass-through.
//  - Accept: valid_in && ready_in at posedge N.
//    - The word is written to FIFO[tgt]; valid_outtgt = 1 from cycle N+1.
//    - Latency is 1 cycle.
//  - Pop: popK && valid_outK advances FIFO K's read pointer.
//    - The next word, or empty, is visible the following cycle.
//    - popK on an empty FIFO is ignored; count stays 0 (no underflow).
//  - Push and pop on the same FIFO in the same cycle: the count is unchanged.
//    - Both pointers advance.
//  - Push and pop on different FIFOs in the same cycle are fully independent.
//  - Full FIFO with popK in the same cycle: the push is still refused (ready_in = 0).
//    - Accepted next cycle.
//  - Count range is 0..DEPTH, AW+1 bits wide. Pointers wrap modulo DEPTH.
//  - Words leave each output in acceptance order.
//  - No reordering and no loss while reset_L = 1.
//  - valid_in = 0: no state change, ready_in still reflects the target.
// CONFIGURATION
//  - Macro DEMUX_RR_EN.
//  - Defined: selector is ignored and tgt = rr_ptr.
//    - rr_ptr toggles on every accepted word, never on a refused one.
//    - A full target stalls the input; the other output is not skipped.
//  - Undefined: tgt = selector. There is no rr_ptr register.
// STRUCTURE
//  - Shared package mux_demux_pkg holds the common constants:
//    - BW default 2, DEPTH default 4
//    - OUT0 = 1'b0, OUT1 = 1'b1 destination encodings
//  - One sub-module, demux_fifo:
//    - Parameterised BW/DEPTH, with push, pop, full, empty, head.
//    - Instantiated twice.
//  - The top level holds only target selection, the handshake and rr_ptr.
// TESTING
//  1. Reset mid-stream: FIFO 0 holds 3 words; drop reset_L between edges.
//     -> valid_out0 = 0 and data_out0 = 0 immediately; ready_in = 1.
//  2. Routing: selector = 0, data 2'b01, then selector = 1, data 2'b10.
//     -> data_out0 = 01 and data_out1 = 10, each valid one cycle after its accept.
//  3. Full: push 4 words to out0 with no pop.
//     -> On the 5th, ready_in = 0 and valid_out1 is unaffected.
//     -> pop0 with a push on the same cycle: still refused; accepted next cycle.
//  4. Order and wrap: push 00,01,10,11,00,01 to out1 while popping 1 word in 2.
//     -> They pop in exactly that order across the pointer wrap.
//  5. Simultaneous push and pop on out0 at count 2 -> count stays 2.
//     -> pop1 while FIFO 1 is empty: no state change.
//  6. DEMUX_RR_EN defined, selector held at 1, push a,b,c.
//     -> a to out0, b to out1, c to out0.
//     -> With out1 full, b stalls until pop1 frees an entry.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// Constants shared by the registered mux/demux family: default sizes and
// destination encodings, plus the full-flag lookup for a chosen destination.
package mux_demux_pkg;

  localparam int   BW_DEFAULT    = 2;
  localparam int   DEPTH_DEFAULT = 4;
  localparam logic OUT0          = 1'b0;
  localparam logic OUT1          = 1'b1;

  function automatic logic tgt_full(input logic tgt, input logic full0, input logic full1);
    logic f;
    case (tgt)
      OUT0:    f = full0;
      OUT1:    f = full1;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// DEPTH-entry first-word-fall-through FIFO used once per demux output.
// Push is ignored when full and pop is ignored when empty, so the count never wraps.
module demux_fifo #(
  parameter int BW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic [BW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [BW-1:0] head
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == {(AW+1){1'b0}});
  assign head   = r_mem[r_rd_ptr];

  // Storage: cleared on reset so an empty output reads as zero.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {BW{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux1_2_flops.sv
// 1:2 demultiplexer with a FIFO per output. Macro DEMUX_RR_EN replaces the
// selector input with an internal round-robin pointer that advances per accepted word.
module demux1_2_flops #(
  parameter int BW    = mux_demux_pkg::BW_DEFAULT,
  parameter int DEPTH = mux_demux_pkg::DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          selector,
  input  logic          valid_in,
  input  logic [BW-1:0] data_in,
  output logic          ready_in,
  input  logic          pop0,
  output logic          valid_out0,
  output logic [BW-1:0] data_out0,
  input  logic          pop1,
  output logic          valid_out1,
  output logic [BW-1:0] data_out1
);

  import mux_demux_pkg::*;

  logic w_tgt;
  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_accept;
  logic w_push0;
  logic w_push1;

`ifdef DEMUX_RR_EN
  logic r_rr_ptr;

  // Round-robin pointer: moves only on an accepted word, so a full target stalls.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rr_ptr <= OUT0;
    end else if (w_accept) begin
      r_rr_ptr <= ~r_rr_ptr;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign w_tgt = r_rr_ptr;
`else
  assign w_tgt = selector;
`endif

  // Readiness looks only at the target's fullness, never at the pops.
  assign ready_in = !tgt_full(w_tgt, w_full0, w_full1);
  assign w_accept = valid_in && ready_in;

  // Steer the accepted word to exactly one FIFO.
  always_comb begin
    w_push0 = 1'b0;
    w_push1 = 1'b0;
    if (w_accept) begin
      case (w_tgt)
        OUT0:    w_push0 = 1'b1;
        OUT1:    w_push1 = 1'b1;
        default: begin
          w_push0 = 1'b0;
          w_push1 = 1'b0;
        end
      endcase
    end else begin
      w_push0 = 1'b0;
      w_push1 = 1'b0;
    end
  end

  demux_fifo #(.BW(BW), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (w_push0),
    .push_data (data_in),
    .pop       (pop0),
    .full      (w_full0),
    .empty     (w_empty0),
    .head      (data_out0)
  );

  demux_fifo #(.BW(BW), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (w_push1),
    .push_data (data_in),
    .pop       (pop1),
    .full      (w_full1),
    .empty     (w_empty1),
    .head      (data_out1)
  );

  assign valid_out0 = !w_empty0;
  assign valid_out1 = !w_empty1;

endmodule
